mul_arbiter: RTL and testbench

Round-robin arbiter and two-stage pipeline that shares one Q3.13 fixed-point multiplier among several solver kernels, such as the advection, diffusion and pressure-projection units. Each requester presents an operand pair with a valid/ready handshake. The block grants one requester per cycle and returns the rounded, saturated product together with the requester's index as a tag. It sits between the kernel datapaths and the single DSP-mapped multiplier, so that one multiplier serves every stencil stage.

---
 rtl/mul_arbiter.sv | 123 ++++++++++++
 tb/tb_mul_arbiter.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mul_arbiter.sv
// Round-robin arbiter feeding one shared Q-format multiplier. Two register
// stages: S1 captures the granted operands, S2 holds the rounded, saturated product.
module mul_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16,
  parameter int FRAC    = 13,
  parameter int TAG_W   = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*WIDTH-1:0]   req_a,
  input  logic [NUM_REQ*WIDTH-1:0]   req_b,
  output logic                       resp_valid,
  input  logic                       resp_ready,
  output logic [WIDTH-1:0]           resp_data,
  output logic [TAG_W-1:0]           resp_tag,
  output logic                       resp_sat
);

  localparam logic [TAG_W-1:0] LAST_RST = TAG_W'(NUM_REQ - 1);
  localparam logic signed [2*WIDTH-1:0] RND   = (2*WIDTH)'(1) << (FRAC - 1);
  localparam logic signed [2*WIDTH-1:0] MAX_Q = {{(WIDTH+1){1'b0}}, {(WIDTH-1){1'b1}}};
  localparam logic signed [2*WIDTH-1:0] MIN_Q = {{(WIDTH+1){1'b1}}, {(WIDTH-1){1'b0}}};

  logic [TAG_W-1:0]   last;
  logic [TAG_W-1:0]   grant_idx;
  logic               found;
  logic               stall;
  logic               handshake;
  logic [NUM_REQ-1:0] grant;

  logic               s1_valid;
  logic [WIDTH-1:0]   s1_a;
  logic [WIDTH-1:0]   s1_b;
  logic [TAG_W-1:0]   s1_tag;

  logic [WIDTH-1:0] a_arr [NUM_REQ];
  logic [WIDTH-1:0] b_arr [NUM_REQ];

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_unpack
    assign a_arr[i] = req_a[i*WIDTH +: WIDTH];
    assign b_arr[i] = req_b[i*WIDTH +: WIDTH];
  end

  function automatic logic [TAG_W-1:0] wrap_idx(input logic [TAG_W-1:0] base, input int k);
    int s;
    s = int'(base) + k;
    if (s >= NUM_REQ) s = s - NUM_REQ;
    return s[TAG_W-1:0];
  endfunction

  // Search starts just after the last granted index and wraps once around.
  always_comb begin
    found     = 1'b0;
    grant_idx = '0;
    for (int k = 1; k <= NUM_REQ; k++) begin
      if (!found && req_valid[wrap_idx(last, k)]) begin
        found     = 1'b1;
        grant_idx = wrap_idx(last, k);
      end
    end
  end

  // Handshake: a transfer happens on a rising edge where valid and ready are both
  // high. Ready may depend on valid; a requester holds its operands and valid
  // until that edge. Ready drops for every requester while the output is stalled.
  assign stall     = resp_valid & ~resp_ready;
  assign handshake = found & ~stall & ~rst;
  assign grant     = found ? (NUM_REQ'(1) << grant_idx) : '0;
  assign req_ready = handshake ? grant : '0;

  logic signed [2*WIDTH-1:0] a_ext, b_ext, prod, rnd, q;
  logic [WIDTH-1:0]          sat_data;
  logic                      sat_flag;

  assign a_ext = {{WIDTH{s1_a[WIDTH-1]}}, s1_a};
  assign b_ext = {{WIDTH{s1_b[WIDTH-1]}}, s1_b};
  assign prod  = a_ext * b_ext;
  assign rnd   = prod + RND;
  assign q     = rnd >>> FRAC;

  // Clamp on the full shifted value so overflow never wraps into range.
  always_comb begin
    sat_data = q[WIDTH-1:0];
    sat_flag = 1'b0;
    if (q > MAX_Q) begin
      sat_data = {1'b0, {(WIDTH-1){1'b1}}};
      sat_flag = 1'b1;
    end else if (q < MIN_Q) begin
      sat_data = {1'b1, {(WIDTH-1){1'b0}}};
      sat_flag = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last       <= LAST_RST;
      s1_valid   <= 1'b0;
      s1_a       <= '0;
      s1_b       <= '0;
      s1_tag     <= '0;
      resp_valid <= 1'b0;
      resp_data  <= '0;
      resp_tag   <= '0;
      resp_sat   <= 1'b0;
    end else if (!stall) begin
      s1_valid <= handshake;
      if (handshake) begin
        s1_a   <= a_arr[grant_idx];
        s1_b   <= b_arr[grant_idx];
        s1_tag <= grant_idx;
        last   <= grant_idx;
      end
      resp_valid <= s1_valid;
      resp_data  <= sat_data;
      resp_tag   <= s1_tag;
      resp_sat   <= sat_flag;
    end
  end

endmodule

// File: tb/tb_mul_arbiter.sv
// Directed bench for mul_arbiter: hand-computed products, grant rotation,
// backpressure and mid-stream reset, with an in-order expected-response queue.
module tb_mul_arbiter;

  localparam int N = 4;
  localparam int W = 16;

  logic           clk;
  logic           rst;
  logic [N-1:0]   req_valid;
  logic [N-1:0]   req_ready;
  logic [N*W-1:0] req_a;
  logic [N*W-1:0] req_b;
  logic           resp_valid;
  logic           resp_ready;
  logic [W-1:0]   resp_data;
  logic [1:0]     resp_tag;
  logic           resp_sat;

  mul_arbiter #(.NUM_REQ(N), .WIDTH(W), .FRAC(13), .TAG_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_a      (req_a),
    .req_b      (req_b),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_tag   (resp_tag),
    .resp_sat   (resp_sat)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- scoreboard ----------------
  // entry = {tag[1:0], sat, data[15:0]}
  logic [W+2:0] exp_q[$];
  logic [W-1:0] exp_tab_data [N];
  logic         exp_tab_sat  [N];
  int           m_last;

  always @(negedge clk) begin
    logic [N-1:0] exp_rdy;
    logic         fnd;
    int           idx;
    if (rst) begin
      exp_q.delete();
      m_last = N - 1;
    end else begin
      exp_rdy = '0;
      fnd     = 1'b0;
      if (!(resp_valid && !resp_ready)) begin
        for (int k = 1; k <= N; k++) begin
          idx = (m_last + k) % N;
          if (!fnd && req_valid[idx]) begin
            fnd = 1'b1;
            exp_rdy[idx] = 1'b1;
          end
        end
      end
      check("grant", {28'd0, req_ready}, {28'd0, exp_rdy});
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) begin
          exp_q.push_back({i[1:0], exp_tab_sat[i], exp_tab_data[i]});
          m_last = i;
        end
      end
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          check("stale_resp", {31'd0, resp_valid}, 32'd0);
        end else begin
          check("sb_tag",  {30'd0, resp_tag},  {30'd0, exp_q[0][W+2:W+1]});
          check("sb_sat",  {31'd0, resp_sat},  {31'd0, exp_q[0][W]});
          check("sb_data", {16'd0, resp_data}, {16'd0, exp_q[0][W-1:0]});
          if (resp_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic set_req(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] ed, input logic es);
    req_a[idx*W +: W] = a;
    req_b[idx*W +: W] = b;
    exp_tab_data[idx] = ed;
    exp_tab_sat[idx]  = es;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    req_valid = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  task automatic issue_one(input int idx, input logic [W-1:0] a, input logic [W-1:0] b,
                           input logic [W-1:0] ed, input logic es);
    set_req(idx, a, b, ed, es);
    req_valid = N'(1) << idx;
    @(negedge clk);
    check("hs_ready", {28'd0, req_ready}, {28'd0, N'(1) << idx});
    @(posedge clk);
    #1 req_valid = '0;
    @(negedge clk);
    check("lat_early", {31'd0, resp_valid}, 32'd0);
    @(negedge clk);
    check("lat_valid", {31'd0, resp_valid}, 32'd1);
    check("res_data",  {16'd0, resp_data},  {16'd0, ed});
    check("res_tag",   {30'd0, resp_tag},   idx);
    check("res_sat",   {31'd0, resp_sat},   {31'd0, es});
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int budget;
    budget = 40;
    while ((exp_q.size() != 0 || resp_valid) && budget > 0) begin
      @(posedge clk);
      #1 budget--;
    end
    check("drain_empty", exp_q.size(), 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1);
  end

  // ---------------- stimulus ----------------
  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b1;
    for (int i = 0; i < N; i++) begin
      exp_tab_data[i] = '0;
      exp_tab_sat[i]  = 1'b0;
    end
    do_reset();

    @(negedge clk);
    check("rst_valid", {31'd0, resp_valid}, 32'd0);
    check("rst_data",  {16'd0, resp_data},  32'd0);
    check("rst_tag",   {30'd0, resp_tag},   32'd0);
    check("rst_sat",   {31'd0, resp_sat},   32'd0);
    check("rst_ready", {28'd0, req_ready},  32'd0);
    @(posedge clk);
    #1;

    // single requester, rounding and saturation corners
    issue_one(2, 16'h2000, 16'h3000, 16'h3000, 1'b0);
    issue_one(0, 16'h0001, 16'h1000, 16'h0001, 1'b0);
    issue_one(1, 16'hFFFF, 16'h1000, 16'h0000, 1'b0);
    issue_one(3, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1);
    issue_one(3, 16'h8000, 16'h7FFF, 16'h8000, 1'b1);
    issue_one(1, 16'h8000, 16'h8000, 16'h7FFF, 1'b1);
    issue_one(1, 16'hE000, 16'h2000, 16'hE000, 1'b0);

    // contention: all valid after reset, strict rotation, back-to-back results
    do_reset();
    set_req(0, 16'h2000, 16'h1000, 16'h1000, 1'b0);
    set_req(1, 16'h4000, 16'h3000, 16'h6000, 1'b0);
    set_req(2, 16'hE000, 16'h2000, 16'hE000, 1'b0);
    set_req(3, 16'h7FFF, 16'h7FFF, 16'h7FFF, 1'b1);
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      check("rot_grant", {28'd0, req_ready}, {28'd0, N'(1) << (k % N)});
      if (k >= 2) begin
        check("rot_valid", {31'd0, resp_valid}, 32'd1);
        check("rot_tag",   {30'd0, resp_tag},   (k - 2) % N);
      end
      @(posedge clk);
      #1;
    end
    req_valid = '0;
    for (int k = 8; k < 10; k++) begin
      @(negedge clk);
      check("rot_valid", {31'd0, resp_valid}, 32'd1);
      check("rot_tag",   {30'd0, resp_tag},   (k - 2) % N);
      @(posedge clk);
      #1;
    end
    drain();

    // backpressure: 5 stalled cycles in the middle of a stream
    req_valid = '1;
    repeat (3) @(posedge clk);
    #1 resp_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("bp_ready", {28'd0, req_ready}, 32'd0);
      check("bp_valid", {31'd0, resp_valid}, 32'd1);
      @(posedge clk);
      #1;
    end
    resp_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1 req_valid = '0;
    drain();

    // reset while both stages hold data
    req_valid = '1;
    repeat (3) @(posedge clk);
    #1;
    check("pre_rst_valid", {31'd0, resp_valid}, 32'd1);
    rst = 1'b1;
    req_valid = '0;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("mid_rst_valid", {31'd0, resp_valid}, 32'd0);
    check("mid_rst_data",  {16'd0, resp_data},  32'd0);
    check("mid_rst_tag",   {30'd0, resp_tag},   32'd0);
    check("mid_rst_sat",   {31'd0, resp_sat},   32'd0);
    check("mid_rst_ready", {28'd0, req_ready},  32'd0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      check("no_stale", {31'd0, resp_valid}, 32'd0);
    end
    @(posedge clk);
    #1 req_valid = '1;
    @(negedge clk);
    check("rst_first_grant", {28'd0, req_ready}, 32'd1);
    @(posedge clk);
    #1 req_valid = '0;
    drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
